// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port memory.
// A request sampled in IDLE turns into a one-cycle ACCESS in the next cycle.
// Ties go to the requester that did not own the memory last (round-robin).
// Build option MEM_ARBITER_LOCK_EN: a requester may keep ownership across
// accesses (LOCKED state), bounded by LOCK_MAX cycles. When the bound hits,
// ownership is taken away and lock_err pulses for one cycle.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqx/wex/lockx/adrx/wdx     requester x (x = 0, 1) request, write, lock, address, write data
//   gntx/rdx                    access performed this cycle, read data
//   mem_adr/mem_wd/mem_wr/mem_oe/mem_rd   memory side; mem_rd is combinational
//   owner/locked/lock_err       status
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] wd0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rd0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rd1,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_wr,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              owner,
  output logic              locked,
  output logic              lock_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, LOCKED = 2'd2} state_t;

  state_t r_state, w_next;
  logic   r_owner, w_owner_nxt;

  // Owner-selected request fields
  logic              w_oreq, w_owe, w_act;
  logic [ADDR_W-1:0] w_oadr;
  logic [DATA_W-1:0] w_owd;

  assign w_oreq = r_owner ? req1 : req0;
  assign w_owe  = r_owner ? we1  : we0;
  assign w_oadr = r_owner ? adr1 : adr0;
  assign w_owd  = r_owner ? wd1  : wd0;
  // A request dropped before its grant cycle is withdrawn: no access happens.
  assign w_act  = (r_state == ACCESS) && w_oreq;
  assign owner  = r_owner;

`ifdef MEM_ARBITER_LOCK_EN
  logic       w_olock, w_cap;
  logic       r_lk, w_lk_nxt;     // current ACCESS was entered from LOCKED
  logic       r_err, w_err_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;

  assign w_olock  = r_owner ? lock1 : lock0;
  // True in the cycle whose increment would bring the counter to LOCK_MAX
  assign w_cap    = ({1'b0, r_cnt} + 9'd1) >= 9'(LOCK_MAX);
  assign locked   = (r_state == LOCKED);
  assign lock_err = r_err;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^{lock0, lock1, 8'(LOCK_MAX)};
  assign locked   = 1'b0;
  assign lock_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
      r_lk    <= 1'b0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_owner <= w_owner_nxt;
`ifdef MEM_ARBITER_LOCK_EN
      r_lk    <= w_lk_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_next      = r_state;
    w_owner_nxt = r_owner;
`ifdef MEM_ARBITER_LOCK_EN
    w_lk_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
`endif
    mem_adr = '0;
    mem_wd  = '0;
    mem_wr  = 1'b0;
    mem_oe  = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rd0     = '0;
    rd1     = '0;

    if (w_act) begin
      mem_adr = w_oadr;
      mem_wd  = w_owd;
      mem_wr  = w_owe;
      mem_oe  = ~w_owe;
      gnt0    = ~r_owner;
      gnt1    = r_owner;
      rd0     = r_owner ? '0 : mem_rd;
      rd1     = r_owner ? mem_rd : '0;
    end

    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_next      = ACCESS;
          w_owner_nxt = (req0 && req1) ? ~r_owner : req1;
        end
      end
      ACCESS: begin
        // A request still high at the end of ACCESS is ignored.
        w_next = IDLE;
`ifdef MEM_ARBITER_LOCK_EN
        if (w_act && w_olock) begin
          if (r_lk && w_cap) begin
            w_err_nxt = 1'b1;
          end else begin
            w_next    = LOCKED;
            w_cnt_nxt = r_lk ? r_cnt + 8'd1 : 8'd0;
          end
        end
`endif
      end
      LOCKED: begin
`ifdef MEM_ARBITER_LOCK_EN
        // Only the owner is looked at; a voluntary release takes priority
        // over the forced one.
        if (!w_olock && !w_oreq) begin
          w_next = IDLE;
        end else if (w_cap) begin
          w_next    = IDLE;
          w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (w_oreq) begin
            w_next   = ACCESS;
            w_lk_nxt = 1'b1;
          end
        end
`else
        w_next = IDLE;
`endif
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. Stimulus pushes the expected access per
// grant; a monitor pops and compares whenever a grant is visible, and checks
// the bus is quiet otherwise. Two instances share the stimulus: dut_a with the
// default lock bound and dut_b with LOCK_MAX=4; 'sel' picks the observed one.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [AW-1:0] adr0 = '0, adr1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;

  logic          a_g0, a_g1, a_mwr, a_moe, a_own, a_lkd, a_lerr;
  logic [DW-1:0] a_r0, a_r1, a_mwd, a_mrd;
  logic [AW-1:0] a_ma;
  logic          b_g0, b_g1, b_mwr, b_moe, b_own, b_lkd, b_lerr;
  logic [DW-1:0] b_r0, b_r1, b_mwd, b_mrd;
  logic [AW-1:0] b_ma;

  typedef struct packed {
    logic g0, g1; logic [DW-1:0] r0, r1; logic [AW-1:0] ma; logic [DW-1:0] mwd;
    logic mwr, moe, own, lkd, lerr;
  } obs_t;
  obs_t oa, ob, o;
  logic sel = 1'b0;
  assign oa = {a_g0, a_g1, a_r0, a_r1, a_ma, a_mwd, a_mwr, a_moe, a_own, a_lkd, a_lerr};
  assign ob = {b_g0, b_g1, b_r0, b_r1, b_ma, b_mwd, b_mwr, b_moe, b_own, b_lkd, b_lerr};
  assign o  = sel ? ob : oa;

  // Memory model: 16 words preloaded with 0x100+index
  logic [DW-1:0] mem [16];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
    end else if (o.mwr) begin
      mem[o.ma[3:0]] <= o.mwd;
    end
  end
  assign a_mrd = mem[a_ma[3:0]];
  assign b_mrd = mem[b_ma[3:0]];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .adr0(adr0), .wd0(wd0), .gnt0(a_g0), .rd0(a_r0),
    .req1(req1), .we1(we1), .lock1(lock1), .adr1(adr1), .wd1(wd1), .gnt1(a_g1), .rd1(a_r1),
    .mem_adr(a_ma), .mem_wd(a_mwd), .mem_wr(a_mwr), .mem_oe(a_moe), .mem_rd(a_mrd),
    .owner(a_own), .locked(a_lkd), .lock_err(a_lerr));

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .adr0(adr0), .wd0(wd0), .gnt0(b_g0), .rd0(b_r0),
    .req1(req1), .we1(we1), .lock1(lock1), .adr1(adr1), .wd1(wd1), .gnt1(b_g1), .rd1(b_r1),
    .mem_adr(b_ma), .mem_wd(b_mwd), .mem_wr(b_mwr), .mem_oe(b_moe), .mem_rd(b_mrd),
    .owner(b_own), .locked(b_lkd), .lock_err(b_lerr));

  // Expected grant. at/gap/lk/errs < 0 means "not checked".
  //   at   absolute cycle of the grant
  //   gap  cycles since the previous grant
  //   lk   locked seen high since the previous grant
  //   errs cycles of lock_err high since the previous grant
  typedef struct {
    logic who; logic we; logic [AW-1:0] adr; logic [DW-1:0] d;
    int at; int gap; int lk; int errs;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_err = 0, n_gnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic who, input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] d, input int at, input int gap,
                      input int lk, input int errs);
    exp_t e;
    e.who = who; e.we = we; e.adr = adr; e.d = d;
    e.at = at; e.gap = gap; e.lk = lk; e.errs = errs;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one delay after the edge that closes the grant cycle.
  task automatic wait_gnt(input int tgt);
    int b = 0;
    while (n_gnt < tgt) begin
      if (b == 40) begin
        n_chk++; n_err++;
        $display("FAIL grant_timeout: got %0d grants, expected %0d", n_gnt, tgt);
        break;
      end
      @(posedge clk);
      b++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor
  exp_t e;
  int   lastg = 0, lks = 0, errc = 0;
  initial begin
    forever begin
      @(negedge clk);
      lks  = lks | int'(o.lkd);
      errc = errc + int'(o.lerr);
      if (o.g0 || o.g1) begin
        chk("gnt_onehot", o.g0 & o.g1, 0);
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_grant: got gnt0=%0b gnt1=%0b, expected none", o.g0, o.g1);
        end else begin
          e = q.pop_front();
          chk("gnt_who", o.g1, e.who);
          chk("mem_wr", o.mwr, e.we);
          chk("mem_oe", o.moe, !e.we);
          chk("mem_adr", o.ma, e.adr);
          if (e.we) chk("mem_wd", o.mwd, e.d);
          else      chk("rd_data", e.who ? o.r1 : o.r0, e.d);
          chk("rd_other_zero", e.who ? o.r0 : o.r1, 0);
          if (e.at >= 0)   chk("grant_cycle", cyc, e.at);
          if (e.gap >= 0)  chk("grant_gap", cyc - lastg, e.gap);
          if (e.lk >= 0)   chk("locked_seen", lks, e.lk);
          if (e.errs >= 0) chk("lock_err_cycles", errc, e.errs);
        end
        n_gnt++;
        lastg = cyc; lks = 0; errc = 0;
      end else begin
        chk("quiet_bus", {o.mwr, o.moe, o.ma, o.mwd, o.r0, o.r1}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_gnt", {o.g0, o.g1}, 0);
    chk("rst_strobes", {o.mwr, o.moe}, 0);
    chk("rst_mem_bus", {o.ma, o.mwd}, 0);
    chk("rst_rd", {o.r0, o.r1}, 0);
    chk("rst_status", {o.own, o.lkd, o.lerr}, 0);
    tick();
    rst = 1'b0;

    // Write 0xAA to 5, then read it back
    base = n_gnt;
    req0 = 1; we0 = 1; adr0 = 5; wd0 = 32'hAA;
    push(0, 1, 5, 32'hAA, cyc + 1, -1, 0, 0);
    wait_gnt(base + 1);
    we0 = 0;
    push(0, 0, 5, 32'hAA, cyc + 1, -1, 0, 0);
    wait_gnt(base + 2);
    req0 = 0;

    // Request withdrawn in its grant cycle: no access
    tick();
    req0 = 1; adr0 = 3;
    tick();
    req0 = 0;
    @(negedge clk);
    chk("withdrawn_gnt", {o.g0, o.g1}, 0);
    chk("withdrawn_oe", o.moe, 0);
    tick();

    // Both requesting from reset: 1,0,1,0,... every 2 cycles
    do_reset();
    base = n_gnt;
    req0 = 1; adr0 = 2; req1 = 1; adr1 = 7;
    for (int i = 0; i < 6; i++)
      push((i % 2) == 0, 0, ((i % 2) == 0) ? 8'd7 : 8'd2,
           ((i % 2) == 0) ? 32'h107 : 32'h102,
           (i == 0) ? cyc + 1 : -1, (i == 0) ? -1 : 2, 0, 0);
    wait_gnt(base + 6);
    req0 = 0; req1 = 0;
    tick();

    // Reset during requester 1's write: write completes, owner goes back to 0
    base = n_gnt;
    req1 = 1; we1 = 1; adr1 = 9; wd1 = 32'h55;
    push(1, 1, 9, 32'h55, cyc + 1, -1, 0, 0);
    tick();
    rst = 1; req0 = 1; we0 = 0; adr0 = 9;
    tick();
    we1 = 0;
    @(negedge clk);
    chk("rst_acc_gnt", {o.g0, o.g1}, 0);
    chk("rst_acc_strobes", {o.mwr, o.moe}, 0);
    chk("rst_acc_bus", {o.ma, o.mwd, o.r0, o.r1}, 0);
    chk("rst_acc_owner", o.own, 0);
    tick();
    rst = 0;
    push(1, 0, 9, 32'h55, cyc + 1, -1, 0, 0);
    push(0, 0, 9, 32'h55, -1, 2, 0, 0);
    wait_gnt(base + 3);
    req0 = 0; req1 = 0;
    tick();

`ifdef MEM_ARBITER_LOCK_EN
    // Lock held by 0 across four accesses while 1 waits
    do_reset();
    base = n_gnt;
    req0 = 1; lock0 = 1; we0 = 0; adr0 = 1;
    push(0, 0, 1, 32'h101, cyc + 1, -1, 0, 0);
    tick();
    req1 = 1; we1 = 0; adr1 = 4;
    for (int i = 0; i < 3; i++) push(0, 0, 1, 32'h101, -1, 2, 1, 0);
    push(1, 0, 4, 32'h104, -1, 3, 1, 0);
    wait_gnt(base + 4);
    req0 = 0; lock0 = 0;
    wait_gnt(base + 5);
    req1 = 0;
    tick();

    // LOCK_MAX=4 instance: forced release after 4 locked cycles
    sel = 1;
    do_reset();
    base = n_gnt;
    req0 = 1; lock0 = 1; we0 = 0; adr0 = 1;
    push(0, 0, 1, 32'h101, cyc + 1, -1, 0, 0);
    tick();
    req1 = 1; we1 = 0; adr1 = 4;
    push(0, 0, 1, 32'h101, -1, 2, 1, 0);
    push(0, 0, 1, 32'h101, -1, 2, 1, 0);
    push(1, 0, 4, 32'h104, -1, 2, 0, 1);
    push(0, 0, 1, 32'h101, -1, 2, 0, 0);
    wait_gnt(base + 4);
    req1 = 0;
    wait_gnt(base + 5);
    req0 = 0; lock0 = 0;
    tick();
`else
    // lock0 ignored: same alternation as without it
    do_reset();
    base = n_gnt;
    req0 = 1; lock0 = 1; adr0 = 2; req1 = 1; adr1 = 7;
    for (int i = 0; i < 6; i++)
      push((i % 2) == 0, 0, ((i % 2) == 0) ? 8'd7 : 8'd2,
           ((i % 2) == 0) ? 32'h107 : 32'h102,
           (i == 0) ? cyc + 1 : -1, (i == 0) ? -1 : 2, 0, 0);
    wait_gnt(base + 6);
    req0 = 0; req1 = 0; lock0 = 0;
    tick();
`endif

    tick(); tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
